// File: rtl/exec_state_ctrl.sv
// Exec-state sequencer for the baseline calculator and minimum trigger on the RFDC AXIS stream.
// Optional build macro NEG_PULSE_EN selects the negative-going threshold comparison.
module exec_state_ctrl #(
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128,
  parameter int THRESHOLD_OFFSET     = 410,
  parameter int INIT_DWELL           = 1024,
  parameter int POST_TRG_LEN         = 16
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  input  logic                            I_RUN,
  input  logic                            I_RECALC,
  input  logic                            I_CALC_COMPLETE,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] I_BASELINE,
  output logic [1:0]                      O_EXEC_STATE,
  output logic [ADC_RESOLUTION_WIDTH-1:0] O_BASELINE,
  output logic                            O_TRIGGER,
  output logic                            O_TRG_START,
  output logic [15:0]                     O_TRG_COUNT
);

  localparam int AW  = ADC_RESOLUTION_WIDTH;
  localparam int SPT = S_AXIS_TDATA_WIDTH / 16;
  localparam int DW  = $clog2(INIT_DWELL + 1);
  localparam int PW  = $clog2(POST_TRG_LEN + 1);

  localparam logic [AW:0]   C_OFFSET = (AW + 1)'(THRESHOLD_OFFSET);
  localparam logic [DW-1:0] C_DWELL  = DW'(INIT_DWELL);
  localparam logic [PW-1:0] C_POST   = PW'(POST_TRG_LEN);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_ARMED = 2'b01,
    ST_HOLD  = 2'b10,
    ST_TRG   = 2'b11
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_baseline;
  logic            r_trigger;
  logic            r_trg_start;
  logic [15:0]     r_trg_count;
  logic [DW-1:0]   r_dwell;
  logic [PW-1:0]   r_post;

  state_t          w_state_nxt;
  logic [AW-1:0]   w_baseline_nxt;
  logic            w_trg_start_nxt;
  logic [15:0]     w_trg_count_nxt;
  logic [DW-1:0]   w_dwell_nxt;
  logic [PW-1:0]   w_post_nxt;

  logic [AW:0]     w_thr_calc;
  logic [AW-1:0]   w_thr;
  logic            w_any;
  logic            w_hit;
  logic            w_unused_tdata;

  // Upper nibble of every 16-bit word carries no ADC information.
  assign w_unused_tdata = ^S_AXIS_TDATA;

`ifdef NEG_PULSE_EN
  // A borrow out of the extra bit means the threshold would go negative; floor it at 0.
  assign w_thr_calc = {1'b0, r_baseline} - C_OFFSET;
  assign w_thr      = w_thr_calc[AW] ? '0 : w_thr_calc[AW-1:0];

  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < SPT; i++) begin
      if (S_AXIS_TDATA[i*16 +: AW] < w_thr) w_any = 1'b1;
    end
  end
`else
  assign w_thr_calc = {1'b0, r_baseline} + C_OFFSET;
  assign w_thr      = w_thr_calc[AW] ? '1 : w_thr_calc[AW-1:0];

  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < SPT; i++) begin
      if (S_AXIS_TDATA[i*16 +: AW] > w_thr) w_any = 1'b1;
    end
  end
`endif

  assign w_hit = S_AXIS_TVALID & w_any;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_baseline_nxt  = r_baseline;
    w_trg_start_nxt = 1'b0;
    w_trg_count_nxt = r_trg_count;
    w_dwell_nxt     = r_dwell;
    w_post_nxt      = r_post;

    if (I_RECALC) begin
      w_state_nxt = ST_INIT;
      w_dwell_nxt = '0;
      w_post_nxt  = '0;
    end else if (r_state == ST_INIT) begin
      if (S_AXIS_TVALID && (r_dwell < C_DWELL)) w_dwell_nxt = r_dwell + 1'b1;
      // Dwell gating hides a complete flag left over from the previous calculation.
      if ((r_dwell == C_DWELL) && I_CALC_COMPLETE && I_RUN) begin
        w_state_nxt    = ST_ARMED;
        w_baseline_nxt = I_BASELINE;
      end
    end else if (!I_RUN) begin
      w_state_nxt = ST_ARMED;
    end else begin
      unique case (r_state)
        ST_ARMED: begin
          if (w_hit) begin
            w_state_nxt     = ST_TRG;
            w_trg_start_nxt = 1'b1;
            if (r_trg_count != 16'hFFFF) w_trg_count_nxt = r_trg_count + 16'd1;
          end
        end
        ST_TRG: begin
          if (S_AXIS_TVALID && !w_hit) begin
            w_state_nxt = ST_HOLD;
            w_post_nxt  = PW'(1);
          end
        end
        ST_HOLD: begin
          // A hit here extends the current event rather than starting a new one.
          if (w_hit) begin
            w_state_nxt = ST_TRG;
          end else if (S_AXIS_TVALID) begin
            if (r_post == C_POST) w_state_nxt = ST_ARMED;
            else                  w_post_nxt  = r_post + 1'b1;
          end
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_state     <= ST_INIT;
      r_baseline  <= '0;
      r_trigger   <= 1'b0;
      r_trg_start <= 1'b0;
      r_trg_count <= '0;
      r_dwell     <= '0;
      r_post      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_baseline  <= w_baseline_nxt;
      r_trigger   <= (w_state_nxt == ST_TRG) || (w_state_nxt == ST_HOLD);
      r_trg_start <= w_trg_start_nxt;
      r_trg_count <= w_trg_count_nxt;
      r_dwell     <= w_dwell_nxt;
      r_post      <= w_post_nxt;
    end
  end

  assign O_EXEC_STATE = r_state;
  assign O_BASELINE   = r_baseline;
  assign O_TRIGGER    = r_trigger;
  assign O_TRG_START  = r_trg_start;
  assign O_TRG_COUNT  = r_trg_count;

endmodule
